decode_stage: RTL and testbench
===============================

# decode_stage

Registered, handshaked instruction-decode stage for the 16-bit core, the pipelined successor of the combinational decoder. It accepts fetched instruction words with a valid/ready handshake, decodes them into the same control fields, and holds them in a one-entry output register for execute. New behaviour:
- parametrised immediate and PC widths;
- an EXT prefix word that widens immediates;
- an illegal-instruction flag;
- a pipeline flush input;
- fully defined outputs for every encoding (no latched fields).

## Interface
- DW, 16: immediate output width; legal range 9..16.
- AW, 8: PC tag width.
- CLK  in  1  clock, rising edge.
- RST_N  in  1  reset, asynchronous, active-low.
- FLUSH  in  1  discard held output and pending prefix.
- IN_VALID  in  1  instruction word offered.
- IN_READY  out  1  stage accepts the offered word.
- IN_CMD  in  16  instruction word.
- IN_PC  in  AW  PC of IN_CMD.
- OUT_VALID  out  1  decoded bundle valid.
- OUT_READY  in  1  execute accepts the bundle.
- OUT_PC  out  AW  PC of the decoded instruction. For an EXT-prefixed instruction this is the prefix's PC.
- CAL 4, MODE 2, REG_A 4, REG_B 4, REG_O 4, REG_O_TYPE 2, JUMP_MODE 2, SEL 2  out  decoded fields.
- IMM  out  DW  immediate.
- REG_WRITE, MEM_WRITE, INOUT_FLAG, ILLEGAL  out  1 each.

## Operation
Every field defaults to 0 unless it is listed for the matching class below. Classes are tested in priority order:
- **cmd[15]=1, ALU-imm:** CAL={0,cmd[14:12]}, REG_A=cmd[11:8], IMM=cmd[7:0] zero-extended to DW, SEL=10, REG_WRITE=1.
- **cmd[14]=1, register class:** CAL=cmd[13:10], MODE=cmd[9:8]. Then, by MODE:
  - 00: REG_A=cmd[7:4], REG_B=cmd[3:0], REG_WRITE=1.
  - 01: same register fields, REG_WRITE=0 (compare).
  - 10: REG_O_TYPE=cmd[13:12], INOUT_FLAG=cmd[11], REG_O=cmd[7:4], REG_A=cmd[3:0], SEL=01, REG_WRITE=1.
  - 11: REG_A=cmd[7:4], REG_B=cmd[3:0], REG_WRITE=cmd[10], MEM_WRITE=~cmd[10].
- **cmd[15:12]=0001, misc class, sub-op cmd[7:4]:**
  - 0000, jump: MODE=10, SEL=11, JUMP_MODE=cmd[9:8]. REG_A/REG_B = 12/13 if cmd[3:0]==0, else 14/15.
  - 0001, clear: CAL=1011, REG_A=cmd[3:0], IMM=0, SEL=10, REG_WRITE=1.
  - 0010, jump-register: MODE=10, REG_O_TYPE=10, REG_O=cmd[3:0], SEL=01, JUMP_MODE=10.
  - Any other sub-op: ILLEGAL=1.
- **cmd[15:12]=0010, EXT prefix:** latches EXT_HI=cmd[DW-9:0] and the PC, sets PEND=1, and produces no output.
- **Anything else:** ILLEGAL=1, REG_WRITE=MEM_WRITE=0, SEL=00.
- **Prefix application:** if PEND=1 and the next accepted word is ALU-imm, IMM={EXT_HI, cmd[7:0]}. PEND clears on any accepted non-EXT word.
  - A prefix followed by a non-ALU-imm word is dropped silently; that word decodes normally with its own PC.
  - EXT followed by EXT: the second replaces the first.

## Timing
- Reset: OUT_VALID=0, PEND=0, all output fields and IMM/OUT_PC = 0.
- IN_READY = ~OUT_VALID | OUT_READY (combinational, no bubble).
- Word accepted when IN_VALID & IN_READY. The decoded bundle is registered and appears with OUT_VALID=1 on the next edge: latency 1 cycle, throughput 1/cycle.
- An accepted EXT word: OUT_VALID deasserts next cycle if the held bundle was also consumed, otherwise it is unchanged.
- Back-pressure: while OUT_VALID & ~OUT_READY, the bundle and all fields hold stable.
- FLUSH: takes priority over a simultaneous acceptance. On the next edge OUT_VALID=0 and PEND=0, and the offered word is discarded. IN_READY is unaffected by FLUSH.
- Reset asserted mid-operation returns everything to the reset values immediately (asynchronous).

## Structure
- Shared package decode_pkg holds:
  - class/sub-op opcode constants (ALU-imm, REG, MISC=0001, EXT=0010, JMP=0000, CLR=0001, JR=0010);
  - SEL encodings (NONE=00, OUTREG=01, IM=10, JMP=11);
  - the CAL_CLEAR=1011 constant;
  - a packed decoded-bundle struct.
- Sub-module decode_comb: pure combinational word→bundle decode with all defaults. decode_stage wraps it with the prefix state, handshake register and flush.

## Test plan
- Reset then IN_CMD=16'hA305 accepted → next cycle OUT_VALID=1, CAL=0010, REG_A=3, IMM=16'h0005, SEL=10, REG_WRITE=1.
- EXT 16'h20AB then 16'h8112, back-to-back → exactly one bundle: IMM=16'hAB12, OUT_PC = the EXT's PC. Repeat with 16'h4C31 second → IMM=0, PEND dropped.
- 16'h4F10 (mode 11, cmd[10]=1) → REG_WRITE=1, MEM_WRITE=0. 16'h4B10 → REG_WRITE=0, MEM_WRITE=1.
- 16'h1005 → REG_A=14, REG_B=15, SEL=11. 16'h0000 and 16'h1030 → ILLEGAL=1, no write enables.
- OUT_READY held 0 for 3 cycles with IN_VALID=1 → IN_READY=0, bundle stable, no word lost; stream of 8 words with random stalls → in-order, all 8 delivered.
- FLUSH in the same cycle as an accepted word and with PEND=1 → next cycle OUT_VALID=0; a following ALU-imm gives an unprefixed IMM.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared decode definitions: opcode classes, sub-ops, SEL encodings and the
// decoded control bundle carried from decode to execute.
package decode_pkg;

    localparam int unsigned CMD_W = 16;

    // Class selection: single-bit classes first, then 4-bit class nibbles
    localparam int unsigned BIT_ALU_IMM = 15;
    localparam int unsigned BIT_REG     = 14;
    localparam logic [3:0]  CLS_MISC    = 4'b0001;
    localparam logic [3:0]  CLS_EXT     = 4'b0010;

    // Misc-class sub-ops in cmd[7:4]
    localparam logic [3:0] SUB_JMP = 4'b0000;
    localparam logic [3:0] SUB_CLR = 4'b0001;
    localparam logic [3:0] SUB_JR  = 4'b0010;

    localparam logic [1:0] SEL_NONE   = 2'b00;
    localparam logic [1:0] SEL_OUTREG = 2'b01;
    localparam logic [1:0] SEL_IM     = 2'b10;
    localparam logic [1:0] SEL_JMP    = 2'b11;

    localparam logic [3:0] CAL_CLEAR = 4'b1011;

    typedef struct packed {
        logic [3:0] cal;
        logic [1:0] mode;
        logic [3:0] reg_a;
        logic [3:0] reg_b;
        logic [3:0] reg_o;
        logic [1:0] reg_o_type;
        logic [1:0] jump_mode;
        logic [1:0] sel;
        logic       reg_write;
        logic       mem_write;
        logic       inout_flag;
        logic       illegal;
    } bundle_t;

endpackage

// File: rtl/decode_comb.sv
// Pure combinational instruction-word decode.
// Ports: cmd (instruction word) -> dec_c (control bundle),
//        alu_imm_c (word is ALU-imm, may take a prefix), ext_c (word is EXT prefix).
module decode_comb
    import decode_pkg::*;
(
    input  logic [CMD_W-1:0] cmd,
    output bundle_t          dec_c,
    output logic             alu_imm_c,
    output logic             ext_c
);

    // Class decode in priority order; every field defaults to zero
    always_comb begin
        dec_c     = '0;
        alu_imm_c = 1'b0;
        ext_c     = 1'b0;
        if (cmd[BIT_ALU_IMM]) begin
            dec_c.cal       = {1'b0, cmd[14:12]};
            dec_c.reg_a     = cmd[11:8];
            dec_c.sel       = SEL_IM;
            dec_c.reg_write = 1'b1;
            alu_imm_c       = 1'b1;
        end else if (cmd[BIT_REG]) begin
            dec_c.cal  = cmd[13:10];
            dec_c.mode = cmd[9:8];
            case (cmd[9:8])
                2'b00: begin
                    dec_c.reg_a     = cmd[7:4];
                    dec_c.reg_b     = cmd[3:0];
                    dec_c.reg_write = 1'b1;
                end
                2'b01: begin
                    dec_c.reg_a = cmd[7:4];
                    dec_c.reg_b = cmd[3:0];
                end
                2'b10: begin
                    dec_c.reg_o_type = cmd[13:12];
                    dec_c.inout_flag = cmd[11];
                    dec_c.reg_o      = cmd[7:4];
                    dec_c.reg_a      = cmd[3:0];
                    dec_c.sel        = SEL_OUTREG;
                    dec_c.reg_write  = 1'b1;
                end
                default: begin
                    dec_c.reg_a     = cmd[7:4];
                    dec_c.reg_b     = cmd[3:0];
                    dec_c.reg_write = cmd[10];
                    dec_c.mem_write = ~cmd[10];
                end
            endcase
        end else if (cmd[15:12] == CLS_MISC) begin
            case (cmd[7:4])
                SUB_JMP: begin
                    dec_c.mode      = 2'b10;
                    dec_c.sel       = SEL_JMP;
                    dec_c.jump_mode = cmd[9:8];
                    dec_c.reg_a     = (cmd[3:0] == 4'd0) ? 4'd12 : 4'd14;
                    dec_c.reg_b     = (cmd[3:0] == 4'd0) ? 4'd13 : 4'd15;
                end
                SUB_CLR: begin
                    dec_c.cal       = CAL_CLEAR;
                    dec_c.reg_a     = cmd[3:0];
                    dec_c.sel       = SEL_IM;
                    dec_c.reg_write = 1'b1;
                end
                SUB_JR: begin
                    dec_c.mode       = 2'b10;
                    dec_c.reg_o_type = 2'b10;
                    dec_c.reg_o      = cmd[3:0];
                    dec_c.sel        = SEL_OUTREG;
                    dec_c.jump_mode  = 2'b10;
                end
                default: dec_c.illegal = 1'b1;
            endcase
        end else if (cmd[15:12] == CLS_EXT) begin
            ext_c = 1'b1;
        end else begin
            dec_c.illegal = 1'b1;
        end
    end

endmodule

// File: rtl/decode_stage.sv
// Registered, handshaked decode stage with EXT immediate prefix and flush.
// Ports: clk/rst_n; flush; in_valid/in_ready/in_cmd/in_pc (fetch side);
//        out_valid/out_ready/out_pc plus decoded fields and imm (execute side).
module decode_stage
    import decode_pkg::*;
#(
    parameter int unsigned DW = 16,
    parameter int unsigned AW = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [CMD_W-1:0] in_cmd,
    input  logic [AW-1:0]    in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [AW-1:0]    out_pc,
    output logic [3:0]       cal,
    output logic [1:0]       mode,
    output logic [3:0]       reg_a,
    output logic [3:0]       reg_b,
    output logic [3:0]       reg_o,
    output logic [1:0]       reg_o_type,
    output logic [1:0]       jump_mode,
    output logic [1:0]       sel,
    output logic [DW-1:0]    imm,
    output logic             reg_write,
    output logic             mem_write,
    output logic             inout_flag,
    output logic             illegal
);

    localparam int unsigned EW = DW - 8;

    bundle_t       dec_c;
    bundle_t       held;
    logic          alu_imm_c;
    logic          ext_c;
    logic          accept_c;
    logic          pend;
    logic [EW-1:0] ext_hi;
    logic [AW-1:0] ext_pc;

    decode_comb u_decode_comb (
        .cmd       (in_cmd),
        .dec_c     (dec_c),
        .alu_imm_c (alu_imm_c),
        .ext_c     (ext_c)
    );

    // Free slot whenever nothing is held or the held bundle leaves this cycle
    assign in_ready = ~out_valid | out_ready;
    assign accept_c = in_valid & in_ready;

    // Prefix state and output register; flush wins over acceptance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            pend      <= 1'b0;
            ext_hi    <= '0;
            ext_pc    <= '0;
            held      <= '0;
            imm       <= '0;
            out_pc    <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
            pend      <= 1'b0;
        end else if (accept_c) begin
            if (ext_c) begin
                // Acceptance implies any held bundle was consumed this cycle
                pend      <= 1'b1;
                ext_hi    <= in_cmd[EW-1:0];
                ext_pc    <= in_pc;
                out_valid <= 1'b0;
            end else begin
                pend      <= 1'b0;
                out_valid <= 1'b1;
                held      <= dec_c;
                if (alu_imm_c && pend) begin
                    imm    <= {ext_hi, in_cmd[7:0]};
                    out_pc <= ext_pc;
                end else begin
                    imm    <= alu_imm_c ? DW'(in_cmd[7:0]) : '0;
                    out_pc <= in_pc;
                end
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign cal        = held.cal;
    assign mode       = held.mode;
    assign reg_a      = held.reg_a;
    assign reg_b      = held.reg_b;
    assign reg_o      = held.reg_o;
    assign reg_o_type = held.reg_o_type;
    assign jump_mode  = held.jump_mode;
    assign sel        = held.sel;
    assign reg_write  = held.reg_write;
    assign mem_write  = held.mem_write;
    assign inout_flag = held.inout_flag;
    assign illegal    = held.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage (DW=16, AW=8).
module tb_decode_stage;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_cmd;
    logic [7:0]  in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_pc;
    logic [3:0]  cal;
    logic [1:0]  mode;
    logic [3:0]  reg_a;
    logic [3:0]  reg_b;
    logic [3:0]  reg_o;
    logic [1:0]  reg_o_type;
    logic [1:0]  jump_mode;
    logic [1:0]  sel;
    logic [15:0] imm;
    logic        reg_write;
    logic        mem_write;
    logic        inout_flag;
    logic        illegal;

    int n_vec;
    int n_err;
    int n_rx;

    decode_stage #(.DW(16), .AW(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_cmd     (in_cmd),
        .in_pc      (in_pc),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_pc     (out_pc),
        .cal        (cal),
        .mode       (mode),
        .reg_a      (reg_a),
        .reg_b      (reg_b),
        .reg_o      (reg_o),
        .reg_o_type (reg_o_type),
        .jump_mode  (jump_mode),
        .sel        (sel),
        .imm        (imm),
        .reg_write  (reg_write),
        .mem_write  (mem_write),
        .inout_flag (inout_flag),
        .illegal    (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Offer one word from the next negedge; returns #1 after the accepting edge
    task automatic issue(input logic [15:0] c, input logic [7:0] p);
        bit ok;
        ok = 1'b0;
        @(negedge clk);
        in_valid = 1'b1;
        in_cmd   = c;
        in_pc    = p;
        for (int k = 0; k < 60; k++) begin
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (ok) begin
            @(posedge clk);
            #1;
        end else begin
            check("issue_timeout", 32'd0, 32'd1);
        end
        in_valid = 1'b0;
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        n_rx      = 0;
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_cmd    = '0;
        in_pc     = '0;
        out_ready = 1'b1;

        // Reset state
        #12;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_imm",       32'(imm),       32'd0);
        check("rst_out_pc",    32'(out_pc),    32'd0);
        check("rst_cal",       32'(cal),       32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // ALU-imm
        issue(16'hA305, 8'h10);
        check("alu_valid", 32'(out_valid), 32'd1);
        check("alu_cal",   32'(cal),       32'h2);
        check("alu_reg_a", 32'(reg_a),     32'h3);
        check("alu_imm",   32'(imm),       32'h0005);
        check("alu_sel",   32'(sel),       32'h2);
        check("alu_rw",    32'(reg_write), 32'd1);
        check("alu_pc",    32'(out_pc),    32'h10);

        // EXT + ALU-imm back-to-back
        issue(16'h20AB, 8'h20);
        check("ext_no_out", 32'(out_valid), 32'd0);
        issue(16'h8112, 8'h21);
        check("pfx_valid", 32'(out_valid), 32'd1);
        check("pfx_imm",   32'(imm),       32'hAB12);
        check("pfx_pc",    32'(out_pc),    32'h20);
        check("pfx_reg_a", 32'(reg_a),     32'h1);
        idle_cycle();
        check("pfx_one_bundle", 32'(out_valid), 32'd0);

        // EXT dropped by a register-class word
        issue(16'h20AB, 8'h30);
        issue(16'h4C31, 8'h31);
        check("drop_cal",  32'(cal),       32'h3);
        check("drop_a",    32'(reg_a),     32'h3);
        check("drop_b",    32'(reg_b),     32'h1);
        check("drop_imm",  32'(imm),       32'h0);
        check("drop_pc",   32'(out_pc),    32'h31);
        check("drop_rw",   32'(reg_write), 32'd1);
        issue(16'h8112, 8'h32);
        check("drop_next_imm", 32'(imm),    32'h0012);
        check("drop_next_pc",  32'(out_pc), 32'h32);

        // Mode 11 load/store split
        issue(16'h4F10, 8'h33);
        check("m11a_rw", 32'(reg_write), 32'd1);
        check("m11a_mw", 32'(mem_write), 32'd0);
        check("m11a_md", 32'(mode),      32'h3);
        issue(16'h4B10, 8'h34);
        check("m11b_rw",  32'(reg_write), 32'd0);
        check("m11b_mw",  32'(mem_write), 32'd1);
        check("m11b_cal", 32'(cal),       32'h2);

        // Mode 10 out-register form
        issue(16'h4A56, 8'h35);
        check("m10_inout", 32'(inout_flag), 32'd1);
        check("m10_reg_o", 32'(reg_o),      32'h5);
        check("m10_reg_a", 32'(reg_a),      32'h6);
        check("m10_sel",   32'(sel),        32'h1);
        check("m10_otype", 32'(reg_o_type), 32'h0);

        // Misc class
        issue(16'h1005, 8'h36);
        check("jmp_a",   32'(reg_a),   32'hE);
        check("jmp_b",   32'(reg_b),   32'hF);
        check("jmp_sel", 32'(sel),     32'h3);
        check("jmp_md",  32'(mode),    32'h2);
        check("jmp_ill", 32'(illegal), 32'd0);
        issue(16'h1013, 8'h37);
        check("clr_cal", 32'(cal),       32'hB);
        check("clr_a",   32'(reg_a),     32'h3);
        check("clr_imm", 32'(imm),       32'h0);
        check("clr_rw",  32'(reg_write), 32'd1);
        issue(16'h1027, 8'h38);
        check("jr_reg_o", 32'(reg_o),      32'h7);
        check("jr_otype", 32'(reg_o_type), 32'h2);
        check("jr_jm",    32'(jump_mode),  32'h2);
        check("jr_sel",   32'(sel),        32'h1);

        // Illegal encodings
        issue(16'h0000, 8'h39);
        check("ill0_valid", 32'(out_valid), 32'd1);
        check("ill0_flag",  32'(illegal),   32'd1);
        check("ill0_rw",    32'(reg_write), 32'd0);
        check("ill0_mw",    32'(mem_write), 32'd0);
        check("ill0_sel",   32'(sel),       32'h0);
        issue(16'h1030, 8'h3A);
        check("ill1_flag", 32'(illegal),   32'd1);
        check("ill1_rw",   32'(reg_write), 32'd0);
        check("ill1_mw",   32'(mem_write), 32'd0);

        // Back-pressure for 3 cycles
        idle_cycle();
        @(negedge clk);
        out_ready = 1'b0;
        issue(16'h8001, 8'h40);
        check("bp_first", 32'(imm), 32'h1);
        @(negedge clk);
        in_valid = 1'b1;
        in_cmd   = 16'h8002;
        in_pc    = 8'h41;
        for (int k = 0; k < 3; k++) begin
            check("bp_in_ready", 32'(in_ready),  32'd0);
            check("bp_valid",    32'(out_valid), 32'd1);
            check("bp_imm",      32'(imm),       32'h1);
            check("bp_pc",       32'(out_pc),    32'h40);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("bp_second_imm", 32'(imm),       32'h2);
        check("bp_second_pc",  32'(out_pc),    32'h41);
        check("bp_second_v",   32'(out_valid), 32'd1);
        idle_cycle();

        // Stream of 8 words with random stalls on both sides
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    for (int g = 0; g < int'($urandom_range(0, 2)); g++) @(negedge clk);
                    issue(16'h8000 + 16'(i * 17), 8'(8'h50 + i));
                end
            end
            begin
                for (int cyc = 0; cyc < 300 && n_rx < 8; cyc++) begin
                    @(negedge clk);
                    if (out_valid && out_ready) begin
                        check("stream_imm", 32'(imm),    32'(n_rx * 17));
                        check("stream_pc",  32'(out_pc), 32'(8'h50 + n_rx));
                        n_rx++;
                    end
                    @(posedge clk);
                    #2;
                    out_ready = ($urandom_range(0, 2) != 0);
                end
            end
        join
        check("stream_count", 32'(n_rx), 32'd8);
        @(negedge clk);
        out_ready = 1'b1;
        idle_cycle();

        // Flush against an accepted word with a pending prefix
        issue(16'h20CD, 8'h60);
        @(negedge clk);
        in_valid = 1'b1;
        in_cmd   = 16'h8134;
        in_pc    = 8'h61;
        flush    = 1'b1;
        check("flush_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        check("flush_valid", 32'(out_valid), 32'd0);
        issue(16'h8156, 8'h62);
        check("flush_imm", 32'(imm),    32'h0056);
        check("flush_pc",  32'(out_pc), 32'h62);

        // Asynchronous reset mid-cycle
        issue(16'h8177, 8'h70);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_imm",   32'(imm),       32'h0);
        check("arst_pc",    32'(out_pc),    32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        idle_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
